dispense_sequencer: RTL and testbench

Sequencer downstream of the coffee time selector. On a brew request it walks ingredient indices 0..N_ING-1 and presents each index, with the latched coffee type, to the time selector. It captures the returned 2-bit time value and holds the matching valve open for t_value × TICKS_PER_UNIT clocks. Zero-time ingredients are skipped. A `done` pulse is raised after the last ingredient.

---
 rtl/dispense_sequencer.sv | 122 ++++++++++++
 tb/tb_dispense_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dispense_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dispense_sequencer
// Purpose  : Walks ingredient indices for a latched coffee type, opening each
//            valve for t_value * TICKS_PER_UNIT clocks, then pulses done.
// Revision : 1.0
// ============================================================================
module dispense_sequencer #(
  parameter int unsigned TICKS_PER_UNIT = 50_000_000,
  parameter int unsigned N_ING          = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [2:0]       c_type,
  input  logic [1:0]       t_value,
  output logic [2:0]       c_type_sel,
  output logic [2:0]       ing_type,
  output logic [N_ING-1:0] valve,
  output logic             busy,
  output logic             done
);

  // Timer holds up to 3*TICKS_PER_UNIT-1; the product gets two guard bits.
  localparam int unsigned TW = $clog2(3 * TICKS_PER_UNIT);
  localparam int unsigned PW = TW + 2;
  localparam logic [2:0]  LAST_ING = 3'(N_ING - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_LOAD    = 3'd2,
    S_POUR    = 3'd3,
    S_ADVANCE = 3'd4,
    S_FINISH  = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [TW-1:0]   r_timer;
  logic [TW-1:0]   w_timer_nxt;
  logic [2:0]      w_ctype_nxt;
  logic [2:0]      w_ing_nxt;
  logic [PW-1:0]   w_pour_len;
  logic [TW-1:0]   w_timer_load;

  assign w_pour_len   = PW'(t_value) * PW'(TICKS_PER_UNIT);
  assign w_timer_load = TW'(w_pour_len - PW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
      c_type_sel <= '0;
      ing_type   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_timer    <= w_timer_nxt;
      c_type_sel <= w_ctype_nxt;
      ing_type   <= w_ing_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_ctype_nxt = c_type_sel;
    w_ing_nxt   = ing_type;
    if (abort) begin
      w_state_nxt = S_IDLE;
      w_timer_nxt = '0;
      w_ing_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && (c_type != 3'd0)) begin
            w_ctype_nxt = c_type;
            w_ing_nxt   = '0;
            w_state_nxt = S_WAIT;
          end
        end
        S_WAIT: w_state_nxt = S_LOAD;
        S_LOAD: begin
          if (t_value == 2'd0) begin
            w_state_nxt = S_ADVANCE;
          end else begin
            w_timer_nxt = w_timer_load;
            w_state_nxt = S_POUR;
          end
        end
        S_POUR: begin
          if (r_timer == '0) begin
            w_state_nxt = S_ADVANCE;
          end else begin
            w_timer_nxt = r_timer - TW'(1);
          end
        end
        S_ADVANCE: begin
          if (ing_type == LAST_ING) begin
            w_state_nxt = S_FINISH;
          end else begin
            w_ing_nxt   = ing_type + 3'd1;
            w_state_nxt = S_WAIT;
          end
        end
        S_FINISH: begin
          w_ing_nxt   = '0;
          w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs decode the state register, so an async reset clears them at once.
  assign busy  = (r_state != S_IDLE);
  assign done  = (r_state == S_FINISH);
  assign valve = (r_state == S_POUR) ? (N_ING'(1) << ing_type) : '0;

endmodule
`default_nettype wire

// File: tb/tb_dispense_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dispense_sequencer
// Purpose  : Directed scoreboard bench for dispense_sequencer with a
//            registered time-selector model.
// Revision : 1.0
// ============================================================================
module tb_dispense_sequencer;

  localparam int unsigned TPU = 4;
  localparam int unsigned NI  = 5;

  logic          clk = 1'b0;
  logic          rst_n, start, abort;
  logic [2:0]    c_type;
  logic [1:0]    t_value;
  logic [2:0]    c_type_sel, ing_type;
  logic [NI-1:0] valve;
  logic          busy, done;

  dispense_sequencer #(.TICKS_PER_UNIT(TPU), .N_ING(NI)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .c_type(c_type), .t_value(t_value), .c_type_sel(c_type_sel),
    .ing_type(ing_type), .valve(valve), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] tsel(input logic [2:0] ct, input logic [2:0] ing);
    logic [1:0] r;
    r = 2'd0;
    case (ct)
      3'd1: case (ing) 3'd0: r = 2'd2; 3'd1: r = 2'd3; 3'd4: r = 2'd1; default: r = 2'd0; endcase
      3'd2: case (ing) 3'd0: r = 2'd2; 3'd1: r = 2'd2; 3'd2: r = 2'd1; 3'd4: r = 2'd1; default: r = 2'd0; endcase
      3'd3: r = 2'd1;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) t_value <= 2'd0;
    else        t_value <= tsel(c_type_sel, ing_type);
  end

  typedef struct { int idx; int width; } pulse_t;
  pulse_t exp_p[$];
  int     exp_done[$];
  int     checks = 0;
  int     failures = 0;
  int     cyc = 0;
  int     e0 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_seq(input logic [2:0] ct, input int done_cyc);
    pulse_t p;
    for (int i = 0; i < NI; i++) begin
      if (tsel(ct, 3'(i)) != 2'd0) begin
        p.idx = i;
        p.width = int'(tsel(ct, 3'(i))) * TPU;
        exp_p.push_back(p);
      end
    end
    exp_done.push_back(done_cyc);
  endtask

  task automatic do_start(input logic [2:0] ct);
    c_type = ct;
    start = 1'b1;
    tick(1);
    e0 = cyc;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 200) begin tick(1); n++; end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  // Monitor: measures valve pulses and done timing, pops the scoreboard.
  logic [NI-1:0] cur_v = '0;
  int            width = 0;
  always @(negedge clk) begin
    pulse_t p;
    if (!rst_n) begin
      cur_v = '0;
      width = 0;
    end else begin
      chk("valve_onehot0", {31'd0, $onehot0(valve)}, 32'd1);
      if (valve != '0) begin
        if (cur_v == '0) begin cur_v = valve; width = 1; end
        else width++;
      end else if (cur_v != '0) begin
        if (exp_p.size() == 0) begin
          chk("unexpected_pulse", 32'(cur_v), 32'd0);
        end else begin
          p = exp_p.pop_front();
          chk("pulse_valve", 32'(cur_v), 32'd1 << p.idx);
          chk("pulse_width", width, p.width);
        end
        cur_v = '0;
      end
      if (done) begin
        if (exp_done.size() == 0) chk("unexpected_done", {31'd0, done}, 32'd0);
        else chk("done_cycle", cyc - e0 + 1, exp_done.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; c_type = 3'd0;
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valve", 32'(valve), 32'd0);
    chk("rst_ctype_sel", 32'(c_type_sel), 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // Type 1: widths 8,12,0,0,4; mid-run c_type change and start pulse ignored.
    push_seq(3'd1, 40);
    do_start(3'd1);
    chk("t1_busy_c1", {31'd0, busy}, 32'd1);
    chk("t1_ing_c1", 32'(ing_type), 32'd0);
    chk("t1_ctsel_c1", 32'(c_type_sel), 32'd1);
    tick(19);
    c_type = 3'd3; start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("t1_ctsel_hold", 32'(c_type_sel), 32'd1);
    tick(18);
    chk("t1_done_c39", {31'd0, done}, 32'd0);
    tick(1);
    chk("t1_done_c40", {31'd0, done}, 32'd1);
    chk("t1_busy_c40", {31'd0, busy}, 32'd1);
    tick(1);
    chk("t1_busy_c41", {31'd0, busy}, 32'd0);
    chk("t1_ing_c41", 32'(ing_type), 32'd0);
    tick(3);

    // Type 2: widths 8,8,4,0,4
    push_seq(3'd2, 40);
    do_start(3'd2);
    wait_idle("t2_idle");
    tick(2);

    // c_type 0 request ignored
    c_type = 3'd0; start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("t0_busy", {31'd0, busy}, 32'd0);
    tick(5);
    chk("t0_valve", 32'(valve), 32'd0);

    // abort beats start in the same cycle
    c_type = 3'd1; start = 1'b1; abort = 1'b1;
    tick(1);
    start = 1'b0; abort = 1'b0;
    chk("abort_prio_busy", {31'd0, busy}, 32'd0);
    tick(2);

    // Abort in cycle 5 of valve[1] pour (cycle 18 after start)
    begin
      pulse_t p;
      p.idx = 0; p.width = 8;  exp_p.push_back(p);
      p.idx = 1; p.width = 5;  exp_p.push_back(p);
    end
    do_start(3'd1);
    tick(17);
    chk("abort_pre_valve", 32'(valve), 32'd2);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("abort_valve", 32'(valve), 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_ing", 32'(ing_type), 32'd0);
    tick(50);

    // Clean run after abort
    push_seq(3'd1, 40);
    do_start(3'd1);
    wait_idle("clean_idle");
    tick(2);

    // start held high: second sequence accepted in first IDLE cycle
    push_seq(3'd1, 40);
    push_seq(3'd1, 81);
    c_type = 3'd1; start = 1'b1;
    tick(1);
    e0 = cyc;
    chk("b2b_busy_c1", {31'd0, busy}, 32'd1);
    tick(39);
    chk("b2b_done_c40", {31'd0, done}, 32'd1);
    tick(1);
    chk("b2b_busy_c41", {31'd0, busy}, 32'd0);
    tick(1);
    chk("b2b_busy_c42", {31'd0, busy}, 32'd1);
    start = 1'b0;
    wait_idle("b2b_idle");
    tick(2);

    // Asynchronous reset in the middle of valve[0] pour
    do_start(3'd1);
    tick(4);
    chk("arst_pre_valve", 32'(valve), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valve", 32'(valve), 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_ctsel", 32'(c_type_sel), 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    chk("arst_after_busy", {31'd0, busy}, 32'd0);

    chk("sb_pulses_left", exp_p.size(), 32'd0);
    chk("sb_done_left", exp_done.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
